// File: rtl/bypass_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bypass_accumulator / BypassAdder                                          |
// | Burst accumulator with sticky carry/overflow on a carry-skip adder.       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+

module BypassAdder #(
    parameter int WIDTH      = 32,
    parameter int BLOCK_SIZE = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int NUM_BLOCKS = WIDTH / BLOCK_SIZE;

    always_comb begin : p_add
        logic c;
        logic blk_cin;
        logic prop;
        logic p;
        int   idx;
        sum_o   = '0;
        c       = cin_i;
        blk_cin = 1'b0;
        prop    = 1'b0;
        p       = 1'b0;
        idx     = 0;
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            blk_cin = c;
            prop    = 1'b1;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                idx        = b * BLOCK_SIZE + i;
                p          = a_i[idx] ^ b_i[idx];
                sum_o[idx] = p ^ c;
                c          = (a_i[idx] & b_i[idx]) | (p & c);
                prop       = prop & p;
            end
            // Whole block propagates: the block carry-in skips straight past it.
            if (prop) begin
                c = blk_cin;
            end
        end
        cout_o = c;
    end

endmodule

module bypass_accumulator #(
    parameter int WIDTH      = 32,
    parameter int BLOCK_SIZE = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [0:0] {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   acc_q;
    logic               carry_q;
    logic               ovf_q;
    logic [CNT_W-1:0]   count_q;
    logic               valid_q;

    logic [WIDTH-1:0]   sum_w;
    logic               cout_w;
    logic               beat_w;
    logic [WIDTH-1:0]   acc_d;
    logic               carry_d;
    logic               ovf_d;
    logic [CNT_W-1:0]   count_d;

    BypassAdder #(
        .WIDTH      (WIDTH),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_adder (
        .a_i    (acc_q),
        .b_i    (in_data),
        .cin_i  (1'b0),
        .sum_o  (sum_w),
        .cout_o (cout_w)
    );

    assign in_ready = (state_q == ST_ACC) && !clear;
    assign beat_w   = in_valid && in_ready;

    // Signed overflow: operands agree in sign but the sum does not.
    assign acc_d   = sum_w;
    assign carry_d = carry_q | cout_w;
    assign ovf_d   = ovf_q | ((acc_q[WIDTH-1] == in_data[WIDTH-1]) &&
                              (sum_w[WIDTH-1] != acc_q[WIDTH-1]));
    assign count_d = (&count_q) ? count_q : count_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else if (clear) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (beat_w) begin
                        acc_q   <= acc_d;
                        carry_q <= carry_d;
                        ovf_q   <= ovf_d;
                        count_q <= count_d;
                        if (in_last) begin
                            state_q <= ST_OUT;
                            valid_q <= 1'b1;
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state_q <= ST_ACC;
                        acc_q   <= '0;
                        carry_q <= 1'b0;
                        ovf_q   <= 1'b0;
                        count_q <= '0;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_ACC;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = valid_q;
    assign out_sum   = acc_q;
    assign out_carry = carry_q;
    assign out_ovf   = ovf_q;
    assign out_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_bypass_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bypass_accumulator                                                     |
// | Directed bench with a reference model checked every cycle.               |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+

module tb_bypass_accumulator;

    localparam int W    = 32;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_carry;
    logic          out_ovf;
    logic [CW-1:0] out_count;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    bypass_accumulator #(.WIDTH(W), .BLOCK_SIZE(4), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference model: plain wide arithmetic on the burst rules.
    logic [W-1:0] m_acc = '0;
    logic         m_c   = 1'b0;
    logic         m_o   = 1'b0;
    logic         m_out = 1'b0;
    int           m_cnt = 0;

    function automatic logic carry_of(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] t;
        t = {1'b0, a} + {1'b0, b};
        return t[W];
    endfunction

    function automatic logic sovf(input logic [W-1:0] a, input logic [W-1:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear || (m_out && out_ready)) begin
            m_acc <= '0; m_c <= 1'b0; m_o <= 1'b0; m_cnt <= 0; m_out <= 1'b0;
        end else if (!m_out && in_valid) begin
            m_acc <= m_acc + in_data;
            m_c   <= m_c | carry_of(m_acc, in_data);
            m_o   <= m_o | sovf(m_acc, in_data);
            m_cnt <= (m_cnt < CMAX) ? m_cnt + 1 : m_cnt;
            if (in_last) m_out <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_in_ready",  64'(in_ready),  64'(!m_out && !clear));
            chk("cyc_out_valid", 64'(out_valid), 64'(m_out));
            chk("cyc_out_sum",   64'(out_sum),   64'(m_acc));
            chk("cyc_out_carry", 64'(out_carry), 64'(m_c));
            chk("cyc_out_ovf",   64'(out_ovf),   64'(m_o));
            chk("cyc_out_count", 64'(out_count), 64'(m_cnt));
        end
    end

    task automatic send(input logic [W-1:0] d, input logic l, input bit keep, output int waits);
        logic ok;
        ok = 1'b0; waits = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        while (!ok && waits < 40) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            if (!ok) waits++;
        end
        if (!ok) chk("send_timeout", 64'(ok), 64'd1);
        in_last = 1'b0;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic expect_res(input string nm, input logic [W-1:0] s, input logic c,
                              input logic o, input int cnt);
        int k;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_latency"}, 64'(k), 64'd0);
        chk({nm, "_valid"},   64'(out_valid), 64'd1);
        chk({nm, "_sum"},     64'(out_sum),   64'(s));
        chk({nm, "_carry"},   64'(out_carry), 64'(c));
        chk({nm, "_ovf"},     64'(out_ovf),   64'(o));
        chk({nm, "_count"},   64'(out_count), 64'(cnt));
    endtask

    int w;

    initial begin
        rst_n = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        in_last = 1'b0; out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum",   64'(out_sum),   64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Basic two-beat burst
        send(32'h00000001, 1'b0, 1'b0, w);
        send(32'h00000001, 1'b1, 1'b0, w);
        expect_res("t1", 32'h00000002, 1'b0, 1'b0, 2);
        @(posedge clk); #1;

        // Unsigned carry, then signed overflow
        send(32'hFFFFFFFF, 1'b0, 1'b0, w);
        send(32'h00000001, 1'b1, 1'b0, w);
        expect_res("t2a", 32'h00000000, 1'b1, 1'b0, 2);
        @(posedge clk); #1;
        send(32'h7FFFFFFF, 1'b0, 1'b0, w);
        send(32'h00000001, 1'b1, 1'b0, w);
        expect_res("t2b", 32'h80000000, 1'b0, 1'b1, 2);
        @(posedge clk); #1;

        // Back-pressure on the result
        out_ready = 1'b0;
        send(32'h12345678, 1'b0, 1'b0, w);
        send(32'h87654321, 1'b0, 1'b0, w);
        send(32'h00000001, 1'b1, 1'b0, w);
        expect_res("t3", 32'h9999999A, 1'b0, 1'b0, 3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold_sum",   64'(out_sum),   64'h9999999A);
            chk("t3_hold_valid", 64'(out_valid), 64'd1);
            chk("t3_hold_ready", 64'(in_ready),  64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t3_cleared_valid", 64'(out_valid), 64'd0);
        chk("t3_cleared_sum",   64'(out_sum),   64'd0);
        @(posedge clk); #1;
        send(32'h00000005, 1'b1, 1'b0, w);
        expect_res("t3n", 32'h00000005, 1'b0, 1'b0, 1);
        @(posedge clk); #1;

        // Abort with clear; a beat offered during clear is refused
        send(32'hAAAAAAAA, 1'b0, 1'b0, w);
        send(32'h55555555, 1'b0, 1'b0, w);
        clear = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF; in_last = 1'b1;
        @(negedge clk);
        chk("t4_clear_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        chk("t4_after_sum",   64'(out_sum),   64'd0);
        chk("t4_after_count", 64'(out_count), 64'd0);
        @(posedge clk); #1;
        send(32'h11111111, 1'b0, 1'b0, w);
        send(32'h22222222, 1'b1, 1'b0, w);
        expect_res("t4", 32'h33333333, 1'b0, 1'b0, 2);
        @(posedge clk); #1;

        // Asynchronous reset mid-burst and while holding a result
        send(32'h12345678, 1'b0, 1'b0, w);
        #2 rst_n = 1'b0;
        #1;
        chk("t5a_valid", 64'(out_valid), 64'd0);
        chk("t5a_sum",   64'(out_sum),   64'd0);
        chk("t5a_count", 64'(out_count), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t5a_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(32'h00000042, 1'b1, 1'b0, w);
        @(negedge clk);
        chk("t5b_pre_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5b_valid", 64'(out_valid), 64'd0);
        chk("t5b_sum",   64'(out_sum),   64'd0);
        @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("t5b_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Back-to-back bursts with in_valid held high: one bubble each
        send(32'h00000001, 1'b0, 1'b1, w);
        send(32'h00000002, 1'b1, 1'b1, w);
        expect_res("t6a", 32'h00000003, 1'b0, 1'b0, 2);
        chk("t6a_bubble_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        send(32'hA5A5A5A5, 1'b1, 1'b1, w);
        chk("t6b_extra_wait", 64'(w), 64'd0);
        expect_res("t6b", 32'hA5A5A5A5, 1'b0, 1'b0, 1);
        @(posedge clk); #1;
        send(32'h00000010, 1'b0, 1'b1, w);
        chk("t6c_extra_wait", 64'(w), 64'd0);
        send(32'h00000020, 1'b1, 1'b0, w);
        expect_res("t6c", 32'h00000030, 1'b0, 1'b0, 2);
        @(posedge clk); #1;

        // Beat counter saturation
        for (int i = 0; i < 18; i++) begin
            send(32'h00000001, (i == 17), 1'b0, w);
        end
        expect_res("t7", 32'h00000012, 1'b0, 1'b0, CMAX);
        @(posedge clk); #1;

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
